multicycle_control: RTL
=======================

# multicycle_control

Multicycle control unit that sequences one instruction at a time through fetch, decode, execute, memory and writeback states. It drives the select and enable signals consumed by the decode stage (RF_WrEn, RF_WrData_sel, RF_B_sel), together with PC, IR, ALU, immediate-extend and data-memory controls. It sits beside the datapath: it reads the current instruction word and the ALU Zero flag, and produces every control strobe.

## Interface
- No parameters.
- Clk  in  1  system clock; all state changes on rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- Instr  in  32  current IR contents; opcode = [31:26], func = [5:0]; stable from the cycle after IR load.
- Zero  in  1  ALU zero flag; sampled only in EXE of beq/bne.
- IR_LdEn  out  1  load IR from instruction memory.
- PC_LdEn  out  1  load PC.
- PC_sel  out  1  0 = PC+4, 1 = PC+4+Immed.
- RF_B_sel  out  1  0 = read port B uses Instr[15:11]; 1 = uses Instr[20:16].
- RF_WrEn  out  1  register-file write enable (write address is Instr[20:16]).
- RF_WrData_sel  out  1  1 = write ALU_out, 0 = write MEM_out.
- ImmExt  out  2  00 sign-ext, 01 zero-fill, 11 sign-ext then <<2.
- ALU_Bin_sel  out  1  0 = RF_B, 1 = Immed.
- ALU_func  out  4  0000 add, 0001 sub, 0010 and, 0011 or, others passed from func[3:0].
- MEM_WrEn  out  1  data-memory write.
- Illegal  out  1  illegal-opcode trap indicator.

## Operation
- States: IF, DEC, EXE, MEM, WB, plus TRAP (only with macro). Reset → IF.
- IF: IR_LdEn=1. Next state is always DEC.
- DEC: classify opcode.
  - R-type: 100000 with func[5:4]=11.
  - addi 110000, andi 110010, ori 110011.
  - lw 001111, sw 011111, beq 000000, bne 000001, b 111111.
- Sequences:
  - R-type: IF, DEC, EXE, WB. ALU_func=func[3:0], ALU_Bin_sel=0, RF_B_sel=0.
  - addi/andi/ori: IF, DEC, EXE, WB. ALU_Bin_sel=1. ImmExt=00 for addi, 01 for andi/ori. ALU_func=add/and/or.
  - lw: IF, DEC, EXE (add, ImmExt 00, Bin=1), MEM, WB with RF_WrData_sel=0.
  - sw: IF, DEC, EXE (add, ImmExt 00, Bin=1), MEM with MEM_WrEn=1. RF_B_sel=1 in DEC, EXE and MEM.
  - beq/bne: IF, DEC, EXE. RF_B_sel=1 in DEC and EXE, ALU sub, Bin=0, ImmExt=11. In EXE: PC_LdEn=1, PC_sel=Zero (beq) or ~Zero (bne).
  - b: IF, DEC. In DEC: ImmExt=11, PC_LdEn=1, PC_sel=1.
- WB: RF_WrEn=1. RF_WrData_sel=1 except for lw.
- PC_LdEn is asserted exactly once per instruction, in its final state. PC_sel=0 there except for taken branches and b.
- Outputs are decoded from the registered state and Instr. Every output not listed for a state is 0. RF_WrData_sel defaults to 1.
- Unrecognized opcode/func: handled per Configuration.

## Timing
- Latency in cycles from IF to the next IF: R-type/immediate 4, lw 5, sw 4, beq/bne 3, b 2.
- RF_WrEn and MEM_WrEn are high for exactly one cycle per instruction, and never both in the same cycle.
- While Rst_n=0: every output is 0 (IR_LdEn included) and state = IF. The first IR_LdEn occurs in the first cycle after release.
- Reset asserted mid-instruction: state returns to IF immediately. No partial write occurs in the cycle where Rst_n is low.
- Zero is ignored in every state except EXE of beq/bne.

## Configuration
- CTRL_ILLEGAL_TRAP_EN defined:
  - An unrecognized opcode in DEC goes to TRAP. TRAP holds Illegal=1 and all other outputs 0 until Rst_n is asserted.
  - PC is not loaded.
- CTRL_ILLEGAL_TRAP_EN undefined:
  - An unrecognized opcode executes as a NOP: DEC asserts PC_LdEn=1, PC_sel=0, then returns to IF.
  - Illegal is tied to 0 and TRAP does not exist.

## Test plan
- Reset held 3 cycles, then released with Instr=0x80231030 (add r3,r1,r2) → all outputs 0 during reset. Then IF, DEC, EXE (ALU_func=0000, Bin=0, RF_B_sel=0), WB (RF_WrEn=1, RF_WrData_sel=1, PC_LdEn=1, PC_sel=0). IR_LdEn again on cycle 5.
- Instr=0x3C250008 (lw) → MEM cycle has MEM_WrEn=0. WB has RF_WrEn=1, RF_WrData_sel=0. Total 5 cycles.
- Instr=0x7C250004 (sw) → RF_B_sel=1 in DEC/EXE/MEM, MEM_WrEn=1 in MEM only, RF_WrEn never set. 4 cycles.
- Instr=0x0025FFFE (beq) with Zero=1 → EXE has PC_LdEn=1, PC_sel=1, ImmExt=11. Repeat with Zero=0 → PC_sel=0. Repeat with bne 0x0425FFFE and Zero=0 → PC_sel=1.
- Instr=0xFC000010 (b) → DEC has PC_LdEn=1, PC_sel=1, then IF on cycle 3. Rst_n pulsed low during an add's EXE → next cycle after release is IF and RF_WrEn is never asserted.
- Instr=0x28000000 (illegal): with macro → Illegal=1 held, no PC_LdEn, until reset. Without macro → PC_LdEn=1, PC_sel=0 in DEC, then IF.

Source files
------------

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle IF/DEC/EXE/MEM/WB control FSM
// Optional illegal-opcode trap state enabled by macro CTRL_ILLEGAL_TRAP_EN.
module multicycle_control (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic [31:0] Instr,
   input  logic        Zero,
   output logic        IR_LdEn,
   output logic        PC_LdEn,
   output logic        PC_sel,
   output logic        RF_B_sel,
   output logic        RF_WrEn,
   output logic        RF_WrData_sel,
   output logic [1:0]  ImmExt,
   output logic        ALU_Bin_sel,
   output logic [3:0]  ALU_func,
   output logic        MEM_WrEn,
   output logic        Illegal
);

`ifdef CTRL_ILLEGAL_TRAP_EN
   typedef enum logic [2:0] {S_IF, S_DEC, S_EXE, S_MEM, S_WB, S_TRAP} state_t;
`else
   typedef enum logic [2:0] {S_IF, S_DEC, S_EXE, S_MEM, S_WB} state_t;
`endif

   state_t r_state;
   state_t w_next;

   logic [5:0] w_op;
   logic       w_rtype, w_addi, w_andi, w_ori, w_lw, w_sw, w_beq, w_bne, w_b;
   logic       w_br, w_legal;
   logic       w_unused;

   assign w_op     = Instr[31:26];
   assign w_rtype  = (w_op == 6'b100000) && (Instr[5:4] == 2'b11);
   assign w_addi   = (w_op == 6'b110000);
   assign w_andi   = (w_op == 6'b110010);
   assign w_ori    = (w_op == 6'b110011);
   assign w_lw     = (w_op == 6'b001111);
   assign w_sw     = (w_op == 6'b011111);
   assign w_beq    = (w_op == 6'b000000);
   assign w_bne    = (w_op == 6'b000001);
   assign w_b      = (w_op == 6'b111111);
   assign w_br     = w_beq | w_bne;
   assign w_legal  = w_rtype | w_addi | w_andi | w_ori | w_lw | w_sw | w_br | w_b;
   assign w_unused = ^Instr[25:6];

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) r_state <= S_IF;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next        = S_IF;
      IR_LdEn       = 1'b0;
      PC_LdEn       = 1'b0;
      PC_sel        = 1'b0;
      RF_B_sel      = 1'b0;
      RF_WrEn       = 1'b0;
      RF_WrData_sel = 1'b1;
      ImmExt        = 2'b00;
      ALU_Bin_sel   = 1'b0;
      ALU_func      = 4'b0000;
      MEM_WrEn      = 1'b0;
      Illegal       = 1'b0;

      case (r_state)
         S_IF: begin
            IR_LdEn = 1'b1;
            w_next  = S_DEC;
         end
         S_DEC: begin
            RF_B_sel = w_sw | w_br;
            if (w_b) begin
               ImmExt  = 2'b11;
               PC_LdEn = 1'b1;
               PC_sel  = 1'b1;
               w_next  = S_IF;
            end else if (!w_legal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
               w_next  = S_TRAP;
`else
               PC_LdEn = 1'b1;
               w_next  = S_IF;
`endif
            end else begin
               w_next = S_EXE;
            end
         end
         S_EXE: begin
            w_next = S_WB;
            if (w_rtype) begin
               ALU_func = Instr[3:0];
            end else if (w_addi) begin
               ALU_Bin_sel = 1'b1;
            end else if (w_andi || w_ori) begin
               ALU_Bin_sel = 1'b1;
               ImmExt      = 2'b01;
               ALU_func    = w_andi ? 4'b0010 : 4'b0011;
            end else if (w_lw || w_sw) begin
               ALU_Bin_sel = 1'b1;
               RF_B_sel    = w_sw;
               w_next      = S_MEM;
            end else if (w_br) begin
               // Branch target add happens outside the ALU; ALU compares via sub.
               RF_B_sel = 1'b1;
               ALU_func = 4'b0001;
               ImmExt   = 2'b11;
               PC_LdEn  = 1'b1;
               PC_sel   = w_beq ? Zero : ~Zero;
               w_next   = S_IF;
            end
         end
         S_MEM: begin
            if (w_sw) begin
               RF_B_sel = 1'b1;
               MEM_WrEn = 1'b1;
               PC_LdEn  = 1'b1;
               w_next   = S_IF;
            end else begin
               w_next = S_WB;
            end
         end
         S_WB: begin
            RF_WrEn       = 1'b1;
            RF_WrData_sel = ~w_lw;
            PC_LdEn       = 1'b1;
            w_next        = S_IF;
         end
`ifdef CTRL_ILLEGAL_TRAP_EN
         S_TRAP: begin
            Illegal       = 1'b1;
            RF_WrData_sel = 1'b0;
            w_next        = S_TRAP;
         end
`endif
         default: w_next = S_IF;
      endcase

      // Outputs are forced quiet for as long as reset is held.
      if (!Rst_n) begin
         IR_LdEn       = 1'b0;
         PC_LdEn       = 1'b0;
         PC_sel        = 1'b0;
         RF_B_sel      = 1'b0;
         RF_WrEn       = 1'b0;
         RF_WrData_sel = 1'b0;
         ImmExt        = 2'b00;
         ALU_Bin_sel   = 1'b0;
         ALU_func      = 4'b0000;
         MEM_WrEn      = 1'b0;
         Illegal       = 1'b0;
      end
   end

endmodule
